// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an async PWM input
// in clk cycles, one registered result plus valid strobe per period.
module pwm_capture #(
  parameter int WIDTH       = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_pwm_in,
  output logic [WIDTH-1:0] o_period_count,
  output logic [WIDTH-1:0] o_high_count,
  output logic             o_valid,
  output logic             o_no_signal,
  output logic             o_level
);

  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [WIDTH-1:0]       r_pcnt;
  logic [WIDTH-1:0]       r_hcnt;
  logic                   r_valid;
  logic                   r_no_sig;
  logic [WIDTH-1:0]       r_period;
  logic [WIDTH-1:0]       r_high;

  logic             w_s;
  logic             w_rise;
  logic [WIDTH-1:0] w_pcnt;
  logic [WIDTH-1:0] w_hcnt;
  logic             w_cap;
  logic             w_ovf;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
      r_prev <= w_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_pcnt  <= w_pcnt;
      r_hcnt  <= w_hcnt;
    end
  end

  always_comb begin
    w_next = r_state;
    w_pcnt = r_pcnt;
    w_hcnt = r_hcnt;
    w_cap  = 1'b0;
    w_ovf  = 1'b0;
    if (!i_enable) begin
      w_next = IDLE;
      w_pcnt = '0;
      w_hcnt = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_next = ARM;
          w_pcnt = '0;
          w_hcnt = '0;
        end
        ARM: begin
          if (w_rise) begin
            w_next = MEASURE;
            w_pcnt = WIDTH'(1);
            w_hcnt = WIDTH'(1);
          end
        end
        MEASURE: begin
          if (w_rise) begin
            w_cap  = 1'b1;
            w_pcnt = WIDTH'(1);
            w_hcnt = WIDTH'(1);
          end else if (r_pcnt == MAX) begin
            // silent too long: give up and re-arm
            w_ovf  = 1'b1;
            w_next = ARM;
            w_pcnt = '0;
            w_hcnt = '0;
          end else begin
            w_pcnt = r_pcnt + WIDTH'(1);
            w_hcnt = r_hcnt + WIDTH'(w_s);
          end
        end
        default: begin
          w_next = IDLE;
          w_pcnt = '0;
          w_hcnt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_no_sig <= 1'b0;
      r_period <= '0;
      r_high   <= '0;
    end else begin
      r_valid <= w_cap;
      if (w_cap) begin
        r_period <= r_pcnt;
        r_high   <= r_hcnt;
        r_no_sig <= 1'b0;
      end else if (w_ovf) begin
        r_no_sig <= 1'b1;
      end
    end
  end

  assign o_period_count = r_period;
  assign o_high_count   = r_high;
  assign o_valid        = r_valid;
  assign o_no_signal    = r_no_sig;
  assign o_level        = w_s;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed + randomized periods checked against a
// per-period result queue built from the driven waveform.
module tb_pwm_capture;

  localparam int W    = 5;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic         pwm;
  logic [W-1:0] pc;
  logic [W-1:0] hc;
  logic         vld;
  logic         nos;
  logic         lvl;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int p;
    int h;
  } res_t;

  res_t exp_q[$];
  bit   have_prev  = 0;
  int   prev_h     = 0;
  int   prev_l     = 0;
  bit   async_mode = 0;
  bit   chain      = 0;
  bit   prev_vld   = 0;
  int   last_vcyc  = 0;
  int   n_valid    = 0;

  pwm_capture #(
    .WIDTH      (W),
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_enable      (en),
    .i_pwm_in      (pwm),
    .o_period_count(pc),
    .o_high_count  (hc),
    .o_valid       (vld),
    .o_no_signal   (nos),
    .o_level       (lvl)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // each new rise closes the previous period, if one is open
  task automatic drive_period(int h, int l);
    if (have_prev)
      exp_q.push_back('{p: prev_h + prev_l, h: prev_h});
    prev_h    = h;
    prev_l    = l;
    have_prev = 1;
    pwm = 1'b1;
    tick(h);
    pwm = 1'b0;
    tick(l);
  endtask

  task automatic start_stream();
    have_prev = 0;
    chain     = 0;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++)
      tick(1);
    check(tag, exp_q.size(), 0);
  endtask

  // output monitor
  initial forever begin
    @(negedge clk);
    if (reset_n && vld) begin
      n_valid++;
      check("valid_width", {31'd0, prev_vld}, 0);
      if (async_mode) begin
        check("async_period",
              {31'd0, (pc >= 19 && pc <= 21)}, 1);
        check("async_high",
              {31'd0, (hc >= 6 && hc <= 7)}, 1);
      end else if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        check("period", 32'(pc), r.p);
        check("high", 32'(hc), r.h);
        if (chain)
          check("valid_spacing", cyc - last_vcyc, r.p);
        chain = 1;
      end
      last_vcyc = cyc;
    end
    prev_vld = reset_n & vld;
  end

  initial begin
    int n0;
    int ht;
    reset_n = 1'b0;
    en      = 1'b0;
    pwm     = 1'b0;
    #17;
    check("rst_period", 32'(pc), 0);
    check("rst_high", 32'(hc), 0);
    check("rst_valid", {31'd0, vld}, 0);
    check("rst_nosig", {31'd0, nos}, 0);
    check("rst_level", {31'd0, lvl}, 0);
    reset_n = 1'b1;
    tick(2);

    pwm = 1'b1;
    tick(4);
    check("level_hi", {31'd0, lvl}, 1);
    pwm = 1'b0;
    tick(4);
    check("level_lo", {31'd0, lvl}, 0);

    en = 1'b1;
    tick(3);
    start_stream();
    repeat (6) drive_period(3, 7);
    repeat (3) drive_period(8, 2);
    repeat (5) drive_period(1, 1);
    repeat (20) drive_period($urandom_range(1, 14),
                             $urandom_range(1, 14));
    repeat (2) drive_period(3, 7);
    drive_period(3, 0);
    have_prev = 0;
    drain("drain_main");

    // constant low after the last rise
    for (int i = 0; i < 100 && nos !== 1'b1; i++)
      tick(1);
    check("nosig_set", {31'd0, nos}, 1);
    check("nosig_delay", cyc - last_vcyc, MAXC);
    check("hold_period", 32'(pc), 10);
    check("hold_high", 32'(hc), 3);
    check("nosig_level", {31'd0, lvl}, 0);
    tick(5);

    start_stream();
    repeat (3) drive_period(2, 4);
    drain("drain_restart");
    check("restart_nosig", {31'd0, nos}, 0);
    check("restart_period", 32'(pc), 6);
    check("restart_high", 32'(hc), 2);

    // enable dropped mid-period
    repeat (2) drive_period(4, 5);
    drive_period(4, 3);
    drain("drain_pre_dis");
    en = 1'b0;
    tick(5);
    en = 1'b1;
    start_stream();
    tick(4);
    n0 = n_valid;
    drive_period(4, 5);
    check("reen_first_rise", n_valid - n0, 0);
    repeat (2) drive_period(4, 5);
    drain("drain_reen");
    check("reen_count", n_valid - n0, 2);

    // async reset mid-period
    repeat (2) drive_period(5, 5);
    drain("drain_pre_rst");
    pwm = 1'b1;
    tick(1);
    #2;
    reset_n = 1'b0;
    pwm     = 1'b0;
    #1;
    check("arst_period", 32'(pc), 0);
    check("arst_high", 32'(hc), 0);
    check("arst_valid", {31'd0, vld}, 0);
    check("arst_nosig", {31'd0, nos}, 0);
    check("arst_level", {31'd0, lvl}, 0);
    tick(2);
    #3;
    reset_n = 1'b1;
    start_stream();
    tick(3);
    n0 = n_valid;
    drive_period(6, 4);
    check("post_rst_first", n_valid - n0, 0);
    repeat (3) drive_period($urandom_range(1, 14),
                            $urandom_range(1, 14));
    drain("drain_post_rst");
    check("post_rst_count", n_valid - n0, 3);

    // clock-asynchronous source, period 20 clk +/- jitter
    en = 1'b0;
    tick(3);
    start_stream();
    async_mode = 1;
    n0 = n_valid;
    en = 1'b1;
    #2;
    repeat (12) begin
      ht  = 2 * $urandom_range(31, 34);
      pwm = 1'b1;
      #(ht);
      pwm = 1'b0;
      #(2 * $urandom_range(98, 102) - ht);
    end
    tick(6);
    async_mode = 0;
    check("async_count", n_valid - n0, 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
